// File: rtl/ccip_mem_responder.sv
// ccip_mem_responder
//   Host-memory stand-in for CCI-P-style request streams. c0 read requests
//   (1/2/4 lines) and c1 write requests are queued in separate FIFOs and
//   serviced from an on-chip line-addressed memory. c0/c1 responses are
//   single-cycle pulses with no back-pressure.
//
//   Parameters : MEM_LINES_LOG2 (memory depth in 512-bit lines), BASE_ADDR
//                (line address of index 0), FIFO_DEPTH_LOG2 (request FIFO
//                depth), ALM_FULL_THRESH (almost-full occupancy).
//   Ports      : clk, reset (sync, active-high)
//                c0_req_*  : read request in; c0_alm_full out
//                c0_rsp_*  : read response out (mdata, cl_num, data)
//                c1_req_*  : write request in; c1_alm_full out
//                c1_rsp_*  : write response out (mdata)
//                err_oob_cnt, err_align_cnt, err_ovf : error status
//   Build option: define CCIP_MEM_RSP_JITTER_EN to add LFSR-driven stalls on
//                read issue and write pop.
module ccip_mem_responder #(
  parameter int unsigned MEM_LINES_LOG2  = 10,
  parameter logic [41:0] BASE_ADDR       = 42'h0,
  parameter int unsigned FIFO_DEPTH_LOG2 = 6,
  parameter int unsigned ALM_FULL_THRESH = 56
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c0_req_valid,
  input  logic [41:0]  c0_req_addr,
  input  logic [1:0]   c0_req_cl_len,
  input  logic [15:0]  c0_req_mdata,
  output logic         c0_alm_full,
  output logic         c0_rsp_valid,
  output logic [15:0]  c0_rsp_mdata,
  output logic [1:0]   c0_rsp_cl_num,
  output logic [511:0] c0_rsp_data,
  input  logic         c1_req_valid,
  input  logic [41:0]  c1_req_addr,
  input  logic [15:0]  c1_req_mdata,
  input  logic [511:0] c1_req_data,
  output logic         c1_alm_full,
  output logic         c1_rsp_valid,
  output logic [15:0]  c1_rsp_mdata,
  output logic [15:0]  err_oob_cnt,
  output logic [15:0]  err_align_cnt,
  output logic         err_ovf
);

  localparam int unsigned DEPTH     = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned MEM_LINES = 1 << MEM_LINES_LOG2;

  typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_ALM  = cnt_t'(ALM_FULL_THRESH);

  typedef enum logic {RD_IDLE, RD_BEAT} rd_state_e;

  // ---------------------------------------------------------------------
  // Stall sources
  // ---------------------------------------------------------------------
  logic rd_stall;
  logic wr_stall;

`ifdef CCIP_MEM_RSP_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rd_stall = (lfsr_q[1:0] == 2'b00);
    wr_stall = (lfsr_q[3:2] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
`else
  always_comb begin
    rd_stall = 1'b0;
    wr_stall = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------
  // Read request FIFO
  // ---------------------------------------------------------------------
  logic [41:0] rf_addr  [DEPTH];
  logic [1:0]  rf_len   [DEPTH];
  logic [15:0] rf_mdata [DEPTH];

  ptr_t rf_wp_q, rf_wp_d, rf_rp_q, rf_rp_d;
  cnt_t rf_cnt_q, rf_cnt_d;
  logic rf_full, rf_empty, rf_push, rf_pop;
  logic [41:0] rf_head_addr;
  logic [1:0]  rf_head_len;
  logic [15:0] rf_head_mdata;

  always_comb begin
    rf_full       = (rf_cnt_q == CNT_FULL);
    rf_empty      = (rf_cnt_q == '0);
    rf_push       = c0_req_valid && !rf_full;
    rf_head_addr  = rf_addr[rf_rp_q];
    rf_head_len   = rf_len[rf_rp_q];
    rf_head_mdata = rf_mdata[rf_rp_q];
  end

  always_ff @(posedge clk) begin
    if (rf_push) begin
      rf_addr[rf_wp_q]  <= c0_req_addr;
      rf_len[rf_wp_q]   <= c0_req_cl_len;
      rf_mdata[rf_wp_q] <= c0_req_mdata;
    end
  end

  always_comb begin
    rf_wp_d  = rf_push ? rf_wp_q + ptr_t'(1) : rf_wp_q;
    rf_rp_d  = rf_pop  ? rf_rp_q + ptr_t'(1) : rf_rp_q;
    rf_cnt_d = rf_cnt_q;
    case ({rf_push, rf_pop})
      2'b10:   rf_cnt_d = rf_cnt_q + cnt_t'(1);
      2'b01:   rf_cnt_d = rf_cnt_q - cnt_t'(1);
      default: rf_cnt_d = rf_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Write request FIFO
  // ---------------------------------------------------------------------
  logic [41:0]  wf_addr  [DEPTH];
  logic [15:0]  wf_mdata [DEPTH];
  logic [511:0] wf_data  [DEPTH];

  ptr_t wf_wp_q, wf_wp_d, wf_rp_q, wf_rp_d;
  cnt_t wf_cnt_q, wf_cnt_d;
  logic wf_full, wf_empty, wf_push, wf_pop;
  logic [41:0]  wf_head_addr;
  logic [15:0]  wf_head_mdata;
  logic [511:0] wf_head_data;

  always_comb begin
    wf_full       = (wf_cnt_q == CNT_FULL);
    wf_empty      = (wf_cnt_q == '0);
    wf_push       = c1_req_valid && !wf_full;
    wf_pop        = !wf_empty && !wr_stall;
    wf_head_addr  = wf_addr[wf_rp_q];
    wf_head_mdata = wf_mdata[wf_rp_q];
    wf_head_data  = wf_data[wf_rp_q];
  end

  always_ff @(posedge clk) begin
    if (wf_push) begin
      wf_addr[wf_wp_q]  <= c1_req_addr;
      wf_mdata[wf_wp_q] <= c1_req_mdata;
      wf_data[wf_wp_q]  <= c1_req_data;
    end
  end

  always_comb begin
    wf_wp_d  = wf_push ? wf_wp_q + ptr_t'(1) : wf_wp_q;
    wf_rp_d  = wf_pop  ? wf_rp_q + ptr_t'(1) : wf_rp_q;
    wf_cnt_d = wf_cnt_q;
    case ({wf_push, wf_pop})
      2'b10:   wf_cnt_d = wf_cnt_q + cnt_t'(1);
      2'b01:   wf_cnt_d = wf_cnt_q - cnt_t'(1);
      default: wf_cnt_d = wf_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Read issue FSM
  // ---------------------------------------------------------------------
  rd_state_e   rd_state_q, rd_state_d;
  logic [1:0]  beat_q, beat_d;
  logic [1:0]  last_beat;
  logic [41:0] rd_idx;
  logic        rd_oob, rd_misalign, rd_issue;

  always_comb begin
    // cl_len 2 is not a legal encoding; it is served as a single line
    case (rf_head_len)
      2'd1:    last_beat = 2'd1;
      2'd3:    last_beat = 2'd3;
      default: last_beat = 2'd0;
    endcase
    rd_idx      = rf_head_addr - BASE_ADDR + {40'b0, beat_q};
    rd_oob      = |rd_idx[41:MEM_LINES_LOG2];
    rd_misalign = ((rf_head_len == 2'd1) && rf_head_addr[0]) ||
                  ((rf_head_len == 2'd3) && (rf_head_addr[1:0] != 2'b00));
  end

  always_comb begin
    rd_state_d = rd_state_q;
    beat_d     = beat_q;
    rd_issue   = 1'b0;
    rf_pop     = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (!rf_empty && !rd_stall) begin
          rd_state_d = RD_BEAT;
          beat_d     = 2'd0;
        end
      end
      RD_BEAT: begin
        if (!rd_stall) begin
          rd_issue = 1'b1;
          if (beat_q == last_beat) begin
            rf_pop = 1'b1;
            beat_d = 2'd0;
            // Another entry already queued: start it next cycle without
            // passing through IDLE.
            if (rf_cnt_q == cnt_t'(1)) rd_state_d = RD_IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Line memory (not reset; contents survive reset)
  // ---------------------------------------------------------------------
  logic [511:0] mem [MEM_LINES];
  logic [511:0] mem_rd_q;
  logic [41:0]  wr_idx;
  logic         wr_oob;

  always_comb begin
    wr_idx = wf_head_addr - BASE_ADDR;
    wr_oob = |wr_idx[41:MEM_LINES_LOG2];
  end

  // Read and write share an edge; the read observes the pre-write contents.
  always_ff @(posedge clk) begin
    if (wf_pop && !wr_oob) mem[wr_idx[MEM_LINES_LOG2-1:0]] <= wf_head_data;
    if (rd_issue)          mem_rd_q <= mem[rd_idx[MEM_LINES_LOG2-1:0]];
  end

  // ---------------------------------------------------------------------
  // Response pipelines and status
  // ---------------------------------------------------------------------
  logic         rd_vld_q, rd_vld_d, rd_oob_q, rd_oob_d;
  logic [15:0]  rd_mdata_q, rd_mdata_d;
  logic [1:0]   rd_cl_q, rd_cl_d;
  logic         wr_vld_q, wr_vld_d;
  logic [15:0]  wr_mdata_q, wr_mdata_d;

  logic         c0_rsp_valid_q, c0_rsp_valid_d;
  logic [15:0]  c0_rsp_mdata_q, c0_rsp_mdata_d;
  logic [1:0]   c0_rsp_cl_num_q, c0_rsp_cl_num_d;
  logic [511:0] c0_rsp_data_q, c0_rsp_data_d;
  logic         c1_rsp_valid_q, c1_rsp_valid_d;
  logic [15:0]  c1_rsp_mdata_q, c1_rsp_mdata_d;
  logic         c0_alm_full_q, c0_alm_full_d;
  logic         c1_alm_full_q, c1_alm_full_d;
  logic [15:0]  err_oob_cnt_q, err_oob_cnt_d;
  logic [15:0]  err_align_cnt_q, err_align_cnt_d;
  logic         err_ovf_q, err_ovf_d;
  logic [1:0]   oob_inc;
  logic [16:0]  oob_sum;

  always_comb begin
    rd_vld_d        = rd_issue;
    rd_oob_d        = rd_oob;
    rd_mdata_d      = rf_head_mdata;
    rd_cl_d         = beat_q;
    wr_vld_d        = wf_pop;
    wr_mdata_d      = wf_head_mdata;

    c0_rsp_valid_d  = rd_vld_q;
    c0_rsp_mdata_d  = rd_vld_q ? rd_mdata_q : '0;
    c0_rsp_cl_num_d = rd_vld_q ? rd_cl_q : '0;
    c0_rsp_data_d   = (rd_vld_q && !rd_oob_q) ? mem_rd_q : '0;
    c1_rsp_valid_d  = wr_vld_q;
    c1_rsp_mdata_d  = wr_vld_q ? wr_mdata_q : '0;

    c0_alm_full_d   = (rf_cnt_q >= CNT_ALM);
    c1_alm_full_d   = (wf_cnt_q >= CNT_ALM);

    // A read beat and a write may both be out of range in one cycle.
    oob_inc         = {1'b0, rd_issue & rd_oob} + {1'b0, wf_pop & wr_oob};
    oob_sum         = {1'b0, err_oob_cnt_q} + {15'b0, oob_inc};
    err_oob_cnt_d   = oob_sum[16] ? 16'hFFFF : oob_sum[15:0];

    err_align_cnt_d = err_align_cnt_q;
    if (rd_issue && (beat_q == 2'd0) && rd_misalign && (err_align_cnt_q != 16'hFFFF))
      err_align_cnt_d = err_align_cnt_q + 16'd1;

    err_ovf_d = err_ovf_q | (c0_req_valid & rf_full) | (c1_req_valid & wf_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wp_q         <= '0;
      rf_rp_q         <= '0;
      rf_cnt_q        <= '0;
      wf_wp_q         <= '0;
      wf_rp_q         <= '0;
      wf_cnt_q        <= '0;
      rd_state_q      <= RD_IDLE;
      beat_q          <= '0;
      rd_vld_q        <= 1'b0;
      rd_oob_q        <= 1'b0;
      rd_mdata_q      <= '0;
      rd_cl_q         <= '0;
      wr_vld_q        <= 1'b0;
      wr_mdata_q      <= '0;
      c0_rsp_valid_q  <= 1'b0;
      c0_rsp_mdata_q  <= '0;
      c0_rsp_cl_num_q <= '0;
      c0_rsp_data_q   <= '0;
      c1_rsp_valid_q  <= 1'b0;
      c1_rsp_mdata_q  <= '0;
      c0_alm_full_q   <= 1'b0;
      c1_alm_full_q   <= 1'b0;
      err_oob_cnt_q   <= '0;
      err_align_cnt_q <= '0;
      err_ovf_q       <= 1'b0;
    end else begin
      rf_wp_q         <= rf_wp_d;
      rf_rp_q         <= rf_rp_d;
      rf_cnt_q        <= rf_cnt_d;
      wf_wp_q         <= wf_wp_d;
      wf_rp_q         <= wf_rp_d;
      wf_cnt_q        <= wf_cnt_d;
      rd_state_q      <= rd_state_d;
      beat_q          <= beat_d;
      rd_vld_q        <= rd_vld_d;
      rd_oob_q        <= rd_oob_d;
      rd_mdata_q      <= rd_mdata_d;
      rd_cl_q         <= rd_cl_d;
      wr_vld_q        <= wr_vld_d;
      wr_mdata_q      <= wr_mdata_d;
      c0_rsp_valid_q  <= c0_rsp_valid_d;
      c0_rsp_mdata_q  <= c0_rsp_mdata_d;
      c0_rsp_cl_num_q <= c0_rsp_cl_num_d;
      c0_rsp_data_q   <= c0_rsp_data_d;
      c1_rsp_valid_q  <= c1_rsp_valid_d;
      c1_rsp_mdata_q  <= c1_rsp_mdata_d;
      c0_alm_full_q   <= c0_alm_full_d;
      c1_alm_full_q   <= c1_alm_full_d;
      err_oob_cnt_q   <= err_oob_cnt_d;
      err_align_cnt_q <= err_align_cnt_d;
      err_ovf_q       <= err_ovf_d;
    end
  end

  always_comb begin
    c0_alm_full   = c0_alm_full_q;
    c0_rsp_valid  = c0_rsp_valid_q;
    c0_rsp_mdata  = c0_rsp_mdata_q;
    c0_rsp_cl_num = c0_rsp_cl_num_q;
    c0_rsp_data   = c0_rsp_data_q;
    c1_alm_full   = c1_alm_full_q;
    c1_rsp_valid  = c1_rsp_valid_q;
    c1_rsp_mdata  = c1_rsp_mdata_q;
    err_oob_cnt   = err_oob_cnt_q;
    err_align_cnt = err_align_cnt_q;
    err_ovf       = err_ovf_q;
  end

endmodule

// File: tb/tb_ccip_mem_responder.sv
// Directed bench for ccip_mem_responder (default build, no jitter).
module tb_ccip_mem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         c0_req_valid;
  logic [41:0]  c0_req_addr;
  logic [1:0]   c0_req_cl_len;
  logic [15:0]  c0_req_mdata;
  logic         c0_alm_full;
  logic         c0_rsp_valid;
  logic [15:0]  c0_rsp_mdata;
  logic [1:0]   c0_rsp_cl_num;
  logic [511:0] c0_rsp_data;
  logic         c1_req_valid;
  logic [41:0]  c1_req_addr;
  logic [15:0]  c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         c1_alm_full;
  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;
  logic [15:0]  err_oob_cnt;
  logic [15:0]  err_align_cnt;
  logic         err_ovf;

  ccip_mem_responder #(
    .MEM_LINES_LOG2(10),
    .BASE_ADDR(42'h0),
    .FIFO_DEPTH_LOG2(6),
    .ALM_FULL_THRESH(56)
  ) dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
    .c0_req_cl_len(c0_req_cl_len), .c0_req_mdata(c0_req_mdata),
    .c0_alm_full(c0_alm_full), .c0_rsp_valid(c0_rsp_valid),
    .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_cl_num(c0_rsp_cl_num),
    .c0_rsp_data(c0_rsp_data),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr),
    .c1_req_mdata(c1_req_mdata), .c1_req_data(c1_req_data),
    .c1_alm_full(c1_alm_full), .c1_rsp_valid(c1_rsp_valid),
    .c1_rsp_mdata(c1_rsp_mdata),
    .err_oob_cnt(err_oob_cnt), .err_align_cnt(err_align_cnt), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           cyc;
    logic [15:0]  mdata;
    logic [1:0]   cl;
    logic [511:0] data;
  } rsp0_t;
  typedef struct {
    int          cyc;
    logic [15:0] mdata;
  } rsp1_t;

  rsp0_t q0[$];
  rsp1_t q1[$];

  always @(negedge clk) begin
    if (c0_rsp_valid) q0.push_back('{cyc, c0_rsp_mdata, c0_rsp_cl_num, c0_rsp_data});
    if (c1_rsp_valid) q1.push_back('{cyc, c1_rsp_mdata});
  end

  task automatic chk_d(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_h(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All request tasks start and end 1 time unit after a posedge.
  task automatic rd_req(input logic [41:0] a, input logic [1:0] l, input logic [15:0] m,
                        output int n);
    c0_req_valid  = 1'b1;
    c0_req_addr   = a;
    c0_req_cl_len = l;
    c0_req_mdata  = m;
    @(posedge clk); #1;
    n = cyc;
    c0_req_valid = 1'b0;
  endtask

  task automatic wr_req(input logic [41:0] a, input logic [511:0] d, input logic [15:0] m,
                        output int n);
    c1_req_valid = 1'b1;
    c1_req_addr  = a;
    c1_req_data  = d;
    c1_req_mdata = m;
    @(posedge clk); #1;
    n = cyc;
    c1_req_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic wait_q0(input int want, input int budget, input string name);
    int k = 0;
    while (q0.size() < want && k < budget) begin @(posedge clk); #1; k++; end
    chk_d({name, "_c0_rsp_count"}, q0.size() >= want ? want : q0.size(), want);
  endtask

  task automatic wait_q1(input int want, input int budget, input string name);
    int k = 0;
    while (q1.size() < want && k < budget) begin @(posedge clk); #1; k++; end
    chk_d({name, "_c1_rsp_count"}, q1.size() >= want ? want : q1.size(), want);
  endtask

  function automatic logic [511:0] lpat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 | i;
    return {16{w}};
  endfunction

  typedef struct {
    bit           wr;
    logic [41:0]  addr;
    logic [15:0]  mdata;
    logic [511:0] wdata;
    logic [511:0] exp_data;
    int           exp_lat;
    logic [15:0]  exp_oob;
  } vec_t;

  vec_t vt[11];

  logic [511:0] pat_a, pat_b, pat_c, pat_d0, pat_e, pat_f;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nr, first_alm, mcount, prev, bad;
    bit ovf_m;

    pat_a  = {16{32'hAAAA_0005}};
    pat_b  = {16{32'hBBBB_0003}};
    pat_c  = {16{32'hCCCC_0003}};
    pat_d0 = {16{32'hD000_0000}};
    pat_e  = {16{32'hEEEE_0400}};
    pat_f  = {16{32'hFFFF_03FF}};

    //        wr    addr                  mdata     wdata   exp_data  lat oob
    vt[0]  = '{1'b1, 42'd5,               16'h0011, pat_a,  512'h0,   2,  16'd0};
    vt[1]  = '{1'b0, 42'd5,               16'h0022, 512'h0, pat_a,    3,  16'd0};
    vt[2]  = '{1'b1, 42'd0,               16'h0100, pat_d0, 512'h0,   2,  16'd0};
    vt[3]  = '{1'b0, 42'd0,               16'h0101, 512'h0, pat_d0,   3,  16'd0};
    vt[4]  = '{1'b0, 42'd1024,            16'h0400, 512'h0, 512'h0,   3,  16'd1};
    vt[5]  = '{1'b1, 42'd1024,            16'h0401, pat_e,  512'h0,   2,  16'd2};
    vt[6]  = '{1'b0, 42'd0,               16'h0102, 512'h0, pat_d0,   3,  16'd2};
    vt[7]  = '{1'b1, 42'd1023,            16'h03FF, pat_f,  512'h0,   2,  16'd2};
    vt[8]  = '{1'b0, 42'd1023,            16'h03FE, 512'h0, pat_f,    3,  16'd2};
    vt[9]  = '{1'b1, 42'd3,               16'h0003, pat_b,  512'h0,   2,  16'd2};
    vt[10] = '{1'b0, 42'h3FF_FFFF_FFFF,   16'h0FFF, 512'h0, 512'h0,   3,  16'd3};

    reset = 1'b1;
    c0_req_valid = 1'b0; c0_req_addr = '0; c0_req_cl_len = '0; c0_req_mdata = '0;
    c1_req_valid = 1'b0; c1_req_addr = '0; c1_req_mdata = '0; c1_req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_d("rst_c0_rsp_valid", c0_rsp_valid, 0);
    chk_d("rst_c1_rsp_valid", c1_rsp_valid, 0);
    chk_d("rst_err_oob_cnt", err_oob_cnt, 0);
    chk_d("rst_err_align_cnt", err_align_cnt, 0);
    chk_d("rst_err_ovf", err_ovf, 0);
    chk_d("rst_c0_alm_full", c0_alm_full, 0);
    chk_d("rst_c1_alm_full", c1_alm_full, 0);
    reset = 1'b0;
    idle(2);

    // ---- single-line vectors ----
    for (int i = 0; i < 11; i++) begin
      q0.delete();
      q1.delete();
      if (vt[i].wr) begin
        wr_req(vt[i].addr, vt[i].wdata, vt[i].mdata, n);
        wait_q1(1, 20, $sformatf("vec%0d", i));
        if (q1.size() > 0) begin
          chk_d($sformatf("vec%0d_wr_latency", i), q1[0].cyc - n, vt[i].exp_lat);
          chk_d($sformatf("vec%0d_wr_mdata", i), q1[0].mdata, vt[i].mdata);
        end
      end else begin
        rd_req(vt[i].addr, 2'd0, vt[i].mdata, n);
        wait_q0(1, 20, $sformatf("vec%0d", i));
        if (q0.size() > 0) begin
          chk_d($sformatf("vec%0d_rd_latency", i), q0[0].cyc - n, vt[i].exp_lat);
          chk_d($sformatf("vec%0d_rd_mdata", i), q0[0].mdata, vt[i].mdata);
          chk_d($sformatf("vec%0d_rd_cl_num", i), q0[0].cl, 0);
          chk_h($sformatf("vec%0d_rd_data", i), q0[0].data, vt[i].exp_data);
        end
      end
      idle(4);
      chk_d($sformatf("vec%0d_rsp_total", i), q0.size() + q1.size(), 1);
      chk_d($sformatf("vec%0d_err_oob_cnt", i), err_oob_cnt, vt[i].exp_oob);
    end

    // ---- multi-line reads and alignment ----
    q1.delete();
    for (int k = 0; k < 5; k++) wr_req(42'(8 + k), lpat(8 + k), 16'(16'h0100 + k), n);
    wait_q1(5, 20, "ml_wr");
    for (int k = 0; k < 5 && k < q1.size(); k++)
      chk_d($sformatf("ml_wr%0d_mdata", k), q1[k].mdata, 16'h0100 + k);
    idle(2);

    q0.delete();
    rd_req(42'd8, 2'd3, 16'h0808, n);
    wait_q0(4, 30, "ml_rd8");
    for (int k = 0; k < 4 && k < q0.size(); k++) begin
      chk_d($sformatf("ml_rd8_b%0d_latency", k), q0[k].cyc - n, 3 + k);
      chk_d($sformatf("ml_rd8_b%0d_cl_num", k), q0[k].cl, k);
      chk_d($sformatf("ml_rd8_b%0d_mdata", k), q0[k].mdata, 16'h0808);
      chk_h($sformatf("ml_rd8_b%0d_data", k), q0[k].data, lpat(8 + k));
    end
    idle(4);
    chk_d("ml_rd8_rsp_total", q0.size(), 4);
    chk_d("ml_rd8_err_align_cnt", err_align_cnt, 0);

    q0.delete();
    rd_req(42'd9, 2'd3, 16'h0909, n);
    wait_q0(4, 30, "ml_rd9");
    for (int k = 0; k < 4 && k < q0.size(); k++)
      chk_h($sformatf("ml_rd9_b%0d_data", k), q0[k].data, lpat(9 + k));
    idle(4);
    chk_d("ml_rd9_err_align_cnt", err_align_cnt, 1);

    // cl_len 2 serves one line only
    q0.delete();
    rd_req(42'd8, 2'd2, 16'h0822, n);
    wait_q0(1, 20, "ml_len2");
    idle(8);
    chk_d("ml_len2_rsp_total", q0.size(), 1);
    if (q0.size() > 0) chk_h("ml_len2_data", q0[0].data, lpat(8));
    chk_d("ml_len2_err_align_cnt", err_align_cnt, 1);

    // two-line reads: index 10 aligned, index 11 misaligned
    q0.delete();
    rd_req(42'd10, 2'd1, 16'h0A0A, n);
    rd_req(42'd11, 2'd1, 16'h0B0B, nr);
    wait_q0(4, 30, "ml_len1");
    if (q0.size() >= 4) begin
      chk_h("ml_len1_b3_data", q0[3].data, lpat(12));
      chk_d("ml_len1_b3_cl_num", q0[3].cl, 1);
      chk_d("ml_len1_b2_mdata", q0[2].mdata, 16'h0B0B);
      chk_d("ml_len1_b3_latency", q0[3].cyc - n, 6);
    end
    idle(4);
    chk_d("ml_len1_err_align_cnt", err_align_cnt, 2);

    // ---- same-cycle read and write of index 3 ----
    q0.delete();
    q1.delete();
    rd_req(42'd3, 2'd0, 16'h0333, nr);
    wr_req(42'd3, pat_c, 16'h0444, n);
    wait_q0(1, 20, "rw_same");
    if (q0.size() > 0) chk_h("rw_same_old_data", q0[0].data, pat_b);
    wait_q1(1, 20, "rw_same");
    if (q1.size() > 0) chk_d("rw_same_wr_latency", q1[0].cyc - n, 2);
    q0.delete();
    rd_req(42'd3, 2'd0, 16'h0335, nr);
    wait_q0(1, 20, "rw_next");
    if (q0.size() > 0) chk_h("rw_next_new_data", q0[0].data, pat_c);
    idle(4);

    // ---- almost-full and overflow with 4-beat reads draining ----
    // Reads drain at one entry per 4 cycles: pops land at push-relative
    // edges 5, 9, 13, ... while the FIFO stays non-empty.
    chk_d("pre_ovf_err_ovf", err_ovf, 0);
    q0.delete();
    mcount = 0;
    ovf_m = 1'b0;
    first_alm = -1;
    for (int i = 0; i < 85; i++) begin
      c0_req_valid  = 1'b1;
      c0_req_addr   = 42'd0;
      c0_req_cl_len = 2'd3;
      c0_req_mdata  = 16'(i);
      @(posedge clk); #1;
      prev = mcount;
      if (mcount == 64) ovf_m = 1'b1;
      mcount = mcount + ((mcount < 64) ? 1 : 0) - ((i >= 5 && (i - 5) % 4 == 0) ? 1 : 0);
      chk_d($sformatf("af_c0_alm_full_i%0d", i), c0_alm_full, (prev >= 56) ? 1 : 0);
      chk_d($sformatf("af_err_ovf_i%0d", i), err_ovf, ovf_m);
      if (c0_alm_full && first_alm < 0) first_alm = i;
    end
    c0_req_valid = 1'b0;
    chk_d("af_first_alm_full", first_alm, 73);
    chk_d("af_c1_alm_full", c1_alm_full, 0);
    wait_q0(336, 400, "af_drain");
    idle(10);
    chk_d("af_rsp_total", q0.size(), 336);
    bad = 0;
    foreach (q0[j]) if (q0[j].mdata == 16'd84) bad++;
    chk_d("af_dropped_req_rsps", bad, 0);
    chk_d("af_alm_full_after_drain", c0_alm_full, 0);
    chk_d("af_err_ovf_sticky", err_ovf, 1);

    // ---- reset with reads queued ----
    for (int k = 0; k < 10; k++) rd_req(42'd0, 2'd3, 16'(16'h0A00 + k), n);
    reset = 1'b1;
    @(posedge clk); #1;
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(60);
    chk_d("rstq_c0_rsps", q0.size(), 0);
    chk_d("rstq_c1_rsps", q1.size(), 0);
    chk_d("rstq_err_oob_cnt", err_oob_cnt, 0);
    chk_d("rstq_err_align_cnt", err_align_cnt, 0);
    chk_d("rstq_err_ovf", err_ovf, 0);
    chk_d("rstq_c0_alm_full", c0_alm_full, 0);
    rd_req(42'd5, 2'd0, 16'h0555, n);
    wait_q0(1, 20, "rstq_rd5");
    if (q0.size() > 0) begin
      chk_h("rstq_rd5_data", q0[0].data, pat_a);
      chk_d("rstq_rd5_latency", q0[0].cyc - n, 3);
      chk_d("rstq_rd5_mdata", q0[0].mdata, 16'h0555);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccip_mem_responder.md
# ccip_mem_responder

Host-memory responder for CCI-P-style request streams: accepts c0 read requests and c1 write requests from an AFU, services them from an on-chip line-addressed memory, and returns c0 read responses and c1 write responses with almost-full backpressure. It sits at the FIU end of the link in unit-test and loopback builds, standing in for host memory so copy/filter AFUs can run without the platform shim.

## Interface
- `MEM_LINES_LOG2`, 10: memory depth in 512-bit lines.
- `BASE_ADDR`, 42'h0: cache-line address mapped to memory index 0.
- `FIFO_DEPTH_LOG2`, 6: depth of each request FIFO (64 entries).
- `ALM_FULL_THRESH`, 56: FIFO occupancy at which almost-full asserts.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `c0_req_valid` in 1: read request strobe.
- `c0_req_addr` in 42: cache-line address.
- `c0_req_cl_len` in 2: 0=1 line, 1=2 lines, 3=4 lines.
- `c0_req_mdata` in 16: tag echoed in response.
- `c0_alm_full` out 1: read FIFO count >= ALM_FULL_THRESH.
- `c0_rsp_valid` out 1: read response strobe.
- `c0_rsp_mdata` out 16: echoed tag.
- `c0_rsp_cl_num` out 2: beat index within multi-line response.
- `c0_rsp_data` out 512: line data.
- `c1_req_valid` in 1: write request strobe.
- `c1_req_addr` in 42: cache-line address.
- `c1_req_mdata` in 16: tag.
- `c1_req_data` in 512: line data.
- `c1_alm_full` out 1: write FIFO count >= ALM_FULL_THRESH.
- `c1_rsp_valid` out 1: write response strobe.
- `c1_rsp_mdata` out 16: echoed tag.
- `err_oob_cnt` out 16: out-of-range accesses.
- `err_align_cnt` out 16: misaligned multi-line reads.
- `err_ovf` out 1: sticky, request arrived with FIFO full.

## Operation
- Index = addr - BASE_ADDR (42-bit, wraps). Out of range (index >= 2^MEM_LINES_LOG2): read returns 512'h0, write discarded; response still issued; err_oob_cnt++ per line (saturates at 16'hFFFF).
- Read path: request pushed to read FIFO. Issue FSM: IDLE -> BEAT when FIFO non-empty and not stalled; BEAT issues one memory read per cycle, beat k at index+k, cl_num=k; after beat cl_len, pops FIFO and returns IDLE, or continues directly with next entry (no bubble). cl_len=2 treated as 1 line.
- Multi-line read with addr not aligned to its length: served as-is, err_align_cnt++ once per request.
- Write path: one write FIFO entry popped per cycle, committed to memory, c1 response with mdata one cycle later. One response per request.
- Ordering: a read beat issued in cycle N sees all writes committed in cycles < N; same-cycle read/write to same index returns old data. No ordering between channels otherwise.
- Push when FIFO full: request dropped, no response, err_ovf set until reset.
- Reset: both FIFOs flushed, in-flight beats/responses dropped, FSM to IDLE, all outputs and counters 0, err_ovf 0. Memory contents retained; power-up contents undefined.

## Timing
- Read, empty FIFO, no stall: req at edge N -> push N, issue N+1, memory read N+2, c0_rsp_valid at N+3; further beats on consecutive cycles.
- Sustained throughput: 1 read beat and 1 write per cycle concurrently.
- Write: req at N -> commit N+1, c1_rsp_valid N+2.
- Almost-full registered from count, valid the cycle after the push crossing threshold; ALM_FULL_THRESH leaves 8 entries of slack for the AFU's pipeline.
- Response valids are single-cycle pulses; no ready input (responses are never back-pressured).

## Configuration
- `CCIP_MEM_RSP_JITTER_EN`: defined -> 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5, advances every cycle) stalls read issue and write pop independently when its low 2 bits (reads) / bits [3:2] (writes) are 2'b00; latencies become variable, ordering rules unchanged. Undefined -> no stalls, fixed latencies above.

## Test plan
- Write line 5 = pattern A (mdata 16'h0011), then read line 5 cl_len=0 (mdata 16'h0022) -> c1_rsp mdata 16'h0011 at N+2; c0_rsp data A, mdata 16'h0022, cl_num 0.
- Read addr 8 cl_len=3 -> 4 consecutive responses, cl_num 0..3, data of lines 8..11, same mdata; addr 9 cl_len=3 -> err_align_cnt=1.
- Push 64 reads with issue stalled (jitter or held) -> c0_alm_full high after 56th; 65th push -> dropped, err_ovf=1.
- Read index 1024 (MEM_LINES_LOG2=10) -> data 512'h0, err_oob_cnt=1; write there -> response issued, memory unchanged.
- Same-cycle write and read index 3 (old B, new C) -> read returns B; next read returns C.
- Assert reset with 10 reads queued -> no further responses, counters 0; subsequent read of previously written line returns its data.
